// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, receiver and byte queue.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS       = 8;
  localparam int DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and pulses tick on the final count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_queue_tx.sv
// 8N1 UART transmitter that pulls bytes from an external queue, with zero-gap
// back-to-back frames while the queue stays non-empty.
module uart_queue_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        queue_empty,
  input  logic [7:0]  queue_head_data,
  output logic        dequeue,
  output logic        txd,
  output logic        busy,
  output uart_state_e state_dbg
);

  // Queue handshake: !queue_empty acts as valid for queue_head_data, and
  // dequeue is the ready/pop strobe; a byte transfers on the rising edge
  // where both are high, and queue_head_data is latched on that same edge.

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        fetch;
  logic        can_fetch;
  logic        tick;
  logic        baud_clear;

  assign can_fetch = en && !queue_empty;

  // Counter restarts on every state entry and is held at zero while idle.
  assign baud_clear = (state_d != state_q) || (state_q == ST_IDLE);

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    fetch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (can_fetch) begin
          fetch   = 1'b1;
          shift_d = queue_head_data;
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(FRAME_BITS - 1)) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (can_fetch) begin
            fetch   = 1'b1;
            shift_d = queue_head_data;
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  // Gated with rst_n so no pop can be issued while reset is held.
  assign dequeue   = fetch && rst_n;
  assign txd       = txd_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: doc/uart_queue_tx.md
UART_QUEUE_TX -- requirements
Module: uart_queue_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range is 2 or greater.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port en, input, 1 bit: transmitter enable; no new byte is fetched while low.
REQ-005 SHALL have port queue_empty, input, 1 bit: the byte queue holds no data.
REQ-006 SHALL have port queue_head_data, input, 8 bits: the byte at the queue head, valid whenever queue_empty is low.
REQ-007 SHALL have port dequeue, output, 1 bit: a one-cycle pop strobe to the queue.
REQ-008 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line.

Function
REQ-010 SHALL use frame format 8N1: one start bit (0), data bits D0..D7 sent LSB first, one stop bit (1).
REQ-011 SHALL hold each bit on txd for exactly BAUD_DIV clk cycles, so one frame lasts 10*BAUD_DIV cycles.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP.
REQ-013 SHALL perform a fetch in IDLE when en is high and queue_empty is low: latch queue_head_data into an 8-bit shift register, assert dequeue for that single cycle, and move to START.
REQ-014 SHALL drive txd low starting the cycle after the fetch; fetch-to-start latency is 1 cycle.
REQ-015 SHALL count the DATA bits with a 3-bit index, and SHALL go to STOP after bit 7 has been held BAUD_DIV cycles.
REQ-016 SHALL do the following on the last STOP cycle: if en is high and queue_empty is low, fetch as in REQ-013 and go directly to START (zero idle gap); otherwise go to IDLE.
REQ-017 SHALL never assert dequeue while queue_empty is high, and SHALL never assert it more than once per frame.
REQ-018 SHALL let a frame already in progress complete unchanged when en falls mid-frame, and SHALL make no further fetch; queue contents may be flushed, so the latched byte is authoritative.
REQ-019 SHALL drive busy high in START, DATA and STOP, and low in IDLE.
REQ-020 SHALL size the baud counter to $clog2(BAUD_DIV) bits, clear it to 0 on every state entry, and wrap it at BAUD_DIV-1 with no overflow.
REQ-021 SHALL register txd with no combinational path from any input to txd.
REQ-022 SHALL have queue_head_data changes outside a fetch cycle leave the current frame unaffected.

Reset
REQ-023 SHALL, while rst_n is low, force state to IDLE, txd to 1, dequeue to 0, busy to 0, and the baud counter, bit index and shift register to 0.
REQ-024 SHALL make reset assertion mid-frame abort the frame immediately with txd high; the aborted byte is not re-fetched after release.
REQ-025 SHALL allow the first fetch no earlier than the first clk edge after rst_n deasserts.

Structure
REQ-026 SHALL place the state encoding constants, the frame bit count (8) and the default BAUD_DIV in the shared UART package used by the receiver and the queue.
REQ-027 SHALL implement the baud counter as sub-module uart_baud_tick: inputs clk, rst_n and clear; output tick, high on the count's final cycle.
REQ-028 SHALL contain no FIFO storage of its own; buffering belongs to the external queue.

Verification (BAUD_DIV=4)
REQ-029 SHALL verify a single byte: queue holding 0xA5, en=1 -> dequeue pulses once, and txd reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total.
REQ-030 SHALL verify back-to-back frames: queue holding 0x00 then 0xFF -> two frames with no idle cycle between the stop bit and the next start bit, and exactly 2 dequeue pulses.
REQ-031 SHALL verify the empty queue case: queue_empty=1 for 100 cycles -> dequeue stays 0, txd stays 1, busy stays 0.
REQ-032 SHALL verify en dropped mid-frame: en falls during D3 of 0x3C -> the frame completes correctly, then IDLE with no further dequeue even with queue_empty=0.
REQ-033 SHALL verify reset mid-frame: rst_n low during D5 -> txd=1 and busy=0 in the same cycle; after release with queue holding 0x81, the next frame carries 0x81.
REQ-034 SHALL verify en low at reset release: en=0 with queue_empty=0 -> no dequeue until en rises, then a fetch on the first cycle that en is high.
